sa_arbiter: RTL and testbench
=============================

Name: sa_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one SimpleAdder instance between NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes, issues one add at a time on the adder's sig_ina/sig_inb/sig_en_i, and waits for sig_en_o.
- Returns sig_out to the granted requester as a one-cycle response.
- Sits between requester logic and the adder DUT and drives the adder's input side, the same role the bench driver plays.

Parameters:
- BUS_WIDTH, 4, operand/result width; must match the adder.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 15, WAIT cycles without sig_en_o before an error response is returned (1..255).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*BUS_WIDTH  operand A; requester i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- req_b  input  NUM_REQ*BUS_WIDTH  operand B; same packing as req_a.
- rsp_valid  output  NUM_REQ  one-hot response strobe, one cycle.
- rsp_data  output  BUS_WIDTH  result; valid only while a rsp_valid bit is high.
- rsp_err  output  1  timeout flag, qualified by rsp_valid.
- sig_ina  output  BUS_WIDTH  operand A to the adder.
- sig_inb  output  BUS_WIDTH  operand B to the adder.
- sig_en_i  output  1  adder start, one-cycle pulse.
- sig_out  input  BUS_WIDTH  adder result.
- sig_en_o  input  1  adder result valid.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), timer=0.
- Outputs after reset: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, sig_ina=0, sig_inb=0, sig_en_i=0, busy=0.
- Reset mid-operation aborts the in-flight add. No response is issued. A late sig_en_o after reset is ignored.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, grant g = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally that same cycle. The handshake completes in that cycle.
  - Capture req_a[g] and req_b[g] into operand registers, store g, go to ISSUE.
  - With no req_valid, req_ready=0 and the FSM stays in IDLE.
- ISSUE (1 cycle):
  - sig_ina/sig_inb = captured operands; sig_en_i=1; timer cleared; go to WAIT.
  - sig_ina/sig_inb hold their value until the next ISSUE.
- WAIT:
  - sig_en_i=0. sig_en_o is sampled starting the cycle after the sig_en_i pulse; the adder latency must be at least 1 cycle.
  - If sig_en_o=1: capture sig_out, go to RESP with err=0.
  - Else timer increments. When timer reaches TIMEOUT: go to RESP with err=1 and result 0.
- RESP (1 cycle):
  - rsp_valid[g]=1, rsp_data=result, rsp_err=err.
  - last_grant=g; go to IDLE.
  - rsp_valid, rsp_data and rsp_err return to 0 the next cycle.
  - There is no response backpressure; requesters must sample the response in this cycle.
- Throughput: minimum 4 cycles per operation (IDLE, ISSUE, one WAIT cycle, RESP).
- req_ready is 0 in all states except IDLE. A requester holding req_valid waits; requests are never dropped.
- Width: the result is passed through unmodified at BUS_WIDTH bits. Overflow or carry is the adder's concern; the arbiter never extends or saturates.
- sig_en_o outside WAIT is ignored, including one arriving in RESP after a timeout.
- Simultaneous requests: exactly one grant per arbitration. Every continuously-valid requester is served within NUM_REQ operations.
- req_valid may deassert before a grant without penalty. Operands must be stable while req_valid is high.

Test Plan:
- Single request: rst, then req 0 with a=3, b=5, adder latency 1 -> req_ready[0] high for 1 cycle; sig_en_i pulse carrying 3/5; rsp_valid[0] with rsp_data=8, rsp_err=0; 4 cycles from acceptance to IDLE.
- Wrap pass-through: a=9, b=8 with a 4-bit adder returning 1 -> rsp_data=1, rsp_err=0.
- Round-robin fairness: all four requesters held valid for 5 operations -> grant order 0,1,2,3,0; each rsp_valid is one-hot and matches its grant.
- Timeout: adder never asserts sig_en_o, TIMEOUT=15 -> rsp_valid[g]=1 with rsp_err=1 and rsp_data=0 after 15 WAIT cycles.
- Stray sig_en_o: sig_en_o pulsed during that timeout's RESP cycle and the following IDLE -> ignored; the next operation's result is correct.
- Reset mid-WAIT: assert rst during WAIT for req 2 -> no rsp_valid; all outputs 0 next cycle; next simultaneous requests from 0 and 2 grant 0 first.

Source files
------------

// File: rtl/sa_arbiter.sv
// Round-robin sequencer sharing one adder between NUM_REQ requesters.
// Latency: accept -> response in 3 cycles minimum (ISSUE, WAIT>=1, RESP), 4 cycles per op.
// Backpressure: req_ready only in IDLE; responses are not backpressured.
module sa_arbiter #(
    parameter int BUS_WIDTH = 4,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [BUS_WIDTH-1:0]           rsp_data,
    output logic                           rsp_err,
    output logic [BUS_WIDTH-1:0]           sig_ina,
    output logic [BUS_WIDTH-1:0]           sig_inb,
    output logic                           sig_en_i,
    input  logic [BUS_WIDTH-1:0]           sig_out,
    input  logic                           sig_en_o,
    output logic                           busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [GW-1:0] gidx_t;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    gidx_t                  last_grant_q, last_grant_d;
    gidx_t                  gnt_q, gnt_d;
    logic [BUS_WIDTH-1:0]   ina_q, ina_d;
    logic [BUS_WIDTH-1:0]   inb_q, inb_d;
    logic [7:0]             timer_q, timer_d;
    logic [BUS_WIDTH-1:0]   result_q, result_d;
    logic                   err_q, err_d;

    logic                   arb_found;
    gidx_t                  arb_idx;

    // Search starts one past the last served requester, wrapping modulo NUM_REQ.
    always_comb begin
        int    idx;
        gidx_t cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last_grant_q) + k) % NUM_REQ;
            cand = gidx_t'(idx);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= gidx_t'(NUM_REQ - 1);
            gnt_q        <= '0;
            ina_q        <= '0;
            inb_q        <= '0;
            timer_q      <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            ina_q        <= ina_d;
            inb_q        <= inb_d;
            timer_q      <= timer_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        ina_d        = ina_q;
        inb_d        = inb_q;
        timer_d      = timer_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_d   = arb_idx;
                    ina_d   = req_a[int'(arb_idx)*BUS_WIDTH +: BUS_WIDTH];
                    inb_d   = req_b[int'(arb_idx)*BUS_WIDTH +: BUS_WIDTH];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (sig_en_o) begin
                    result_d = sig_out;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                    if (timer_q == TMO_LAST) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        sig_en_i  = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE:    if (arb_found) req_ready[arb_idx] = 1'b1;
            ISSUE:   sig_en_i = 1'b1;
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                rsp_data         = result_q;
                rsp_err          = err_q;
            end
            default: ;
        endcase
    end

    // Operands stay on the adder inputs until the next grant replaces them.
    assign sig_ina = ina_q;
    assign sig_inb = inb_q;

endmodule

// File: tb/tb_sa_arbiter.sv
// Directed bench for sa_arbiter with a behavioural adder of selectable latency.
module tb_sa_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, rsp_valid;
    logic [15:0] req_a, req_b;
    logic [3:0]  rsp_data, sig_ina, sig_inb, sig_out;
    logic        rsp_err, sig_en_i, sig_en_o, busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wcyc     = 0;

    int          model_lat;
    int          cnt;
    logic [3:0]  sa, sb, model_out;
    logic        model_en, stray_en;

    assign sig_en_o = model_en | stray_en;
    assign sig_out  = model_out;

    always #5 clk = ~clk;

    sa_arbiter #(.BUS_WIDTH(4), .NUM_REQ(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .sig_ina(sig_ina), .sig_inb(sig_inb), .sig_en_i(sig_en_i),
        .sig_out(sig_out), .sig_en_o(sig_en_o), .busy(busy)
    );

    // Adder model: latches operands on the start pulse, answers model_lat cycles later.
    initial begin
        model_en  = 1'b0;
        model_out = '0;
        cnt       = 0;
        sa        = '0;
        sb        = '0;
        forever begin
            @(negedge clk);
            if (sig_en_i === 1'b1 && model_lat > 0) begin
                cnt = model_lat;
                sa  = sig_ina;
                sb  = sig_inb;
            end
            @(posedge clk);
            #1;
            model_en = 1'b0;
            if (cnt == 1) begin
                model_en  = 1'b1;
                model_out = sa + sb;
            end
            if (cnt > 0) cnt--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid == 4'b0 && n < 40) begin
            tick();
            n++;
        end
        wcyc = n;
        chk(tag, 32'(rsp_valid != 4'b0), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_rspv"},  32'(rsp_valid), 0);
        chk({tag, "_rspd"},  32'(rsp_data), 0);
        chk({tag, "_err"},   32'(rsp_err), 0);
        chk({tag, "_ina"},   32'(sig_ina), 0);
        chk({tag, "_inb"},   32'(sig_inb), 0);
        chk({tag, "_en"},    32'(sig_en_i), 0);
        chk({tag, "_busy"},  32'(busy), 0);
    endtask

    initial begin
        logic [3:0] expv;
        int         g;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        model_lat = 1;
        stray_en  = 1'b0;
        repeat (2) tick();
        chk_all_zero("rst");

        // Single request, latency 1: 3 + 5 = 8
        rst          = 1'b0;
        req_valid    = 4'b0001;
        req_a[3:0]   = 4'd3;
        req_b[3:0]   = 4'd5;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_busy_idle", 32'(busy), 0);
        tick();
        req_valid = '0;
        chk("t1_en", 32'(sig_en_i), 1);
        chk("t1_ina", 32'(sig_ina), 3);
        chk("t1_inb", 32'(sig_inb), 5);
        chk("t1_ready_issue", 32'(req_ready), 0);
        chk("t1_busy", 32'(busy), 1);
        tick();
        chk("t1_en_wait", 32'(sig_en_i), 0);
        chk("t1_rsp_wait", 32'(rsp_valid), 0);
        tick();
        chk("t1_rspv", 32'(rsp_valid), 32'h1);
        chk("t1_rspd", 32'(rsp_data), 8);
        chk("t1_err", 32'(rsp_err), 0);
        tick();
        chk("t1_rspv_clr", 32'(rsp_valid), 0);
        chk("t1_rspd_clr", 32'(rsp_data), 0);
        chk("t1_busy_done", 32'(busy), 0);
        chk("t1_ina_hold", 32'(sig_ina), 3);

        // Wrap pass-through, latency 3: 9 + 8 = 17 -> 1 in 4 bits
        model_lat   = 3;
        req_valid   = 4'b0010;
        req_a[7:4]  = 4'd9;
        req_b[7:4]  = 4'd8;
        #1;
        chk("t2_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_rsp("t2_seen");
        chk("t2_lat", 32'(wcyc), 4);
        chk("t2_rspv", 32'(rsp_valid), 32'h2);
        chk("t2_rspd", 32'(rsp_data), 1);
        chk("t2_err", 32'(rsp_err), 0);
        tick();

        // Fairness from reset: all four valid, expect 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        model_lat = 1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4] = 4'(i + 1);
            req_b[i*4 +: 4] = 4'(2 * i);
        end
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            g    = k % 4;
            expv = 4'b0001 << g;
            chk("t3_ready", 32'(req_ready), 32'(expv));
            tick();
            wait_rsp("t3_seen");
            chk("t3_rspv", 32'(rsp_valid), 32'(expv));
            chk("t3_rspd", 32'(rsp_data), 32'(3 * g + 1));
            tick();
        end
        req_valid = '0;

        // Timeout: adder silent, 15 WAIT cycles then error response
        model_lat   = 0;
        req_valid   = 4'b0010;
        req_a[7:4]  = 4'd2;
        req_b[7:4]  = 4'd2;
        #1;
        chk("t4_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_rsp("t4_seen");
        chk("t4_lat", 32'(wcyc), 16);
        chk("t4_rspv", 32'(rsp_valid), 32'h2);
        chk("t4_err", 32'(rsp_err), 1);
        chk("t4_rspd", 32'(rsp_data), 0);

        // Stray sig_en_o in RESP and the following IDLE
        stray_en = 1'b1;
        tick();
        chk("t5_busy", 32'(busy), 0);
        chk("t5_rspv", 32'(rsp_valid), 0);
        model_lat    = 1;
        req_valid    = 4'b0100;
        req_a[11:8]  = 4'd6;
        req_b[11:8]  = 4'd7;
        #1;
        chk("t5_ready", 32'(req_ready), 32'h4);
        tick();
        stray_en  = 1'b0;
        req_valid = '0;
        chk("t5_issue_en", 32'(sig_en_i), 1);
        wait_rsp("t5_seen");
        chk("t5_lat", 32'(wcyc), 2);
        chk("t5_rspv", 32'(rsp_valid), 32'h4);
        chk("t5_rspd", 32'(rsp_data), 13);
        chk("t5_err", 32'(rsp_err), 0);
        tick();

        // Reset during WAIT for requester 2
        model_lat    = 0;
        req_valid    = 4'b0100;
        req_a[11:8]  = 4'd1;
        req_b[11:8]  = 4'd1;
        #1;
        chk("t6_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t6_busy_wait", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk_all_zero("t6_rst");
        rst      = 1'b0;
        stray_en = 1'b1;
        tick();
        chk("t6_stray_rspv", 32'(rsp_valid), 0);
        chk("t6_stray_busy", 32'(busy), 0);
        stray_en    = 1'b0;
        model_lat   = 1;
        req_valid   = 4'b0101;
        req_a[3:0]  = 4'd4;
        req_b[3:0]  = 4'd4;
        req_a[11:8] = 4'd5;
        req_b[11:8] = 4'd5;
        #1;
        chk("t6_ready0", 32'(req_ready), 32'h1);
        tick();
        wait_rsp("t6_seen");
        chk("t6_rspv", 32'(rsp_valid), 32'h1);
        chk("t6_rspd", 32'(rsp_data), 8);
        tick();
        chk("t6_ready2", 32'(req_ready), 32'h4);
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
